// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed 16-bit data memory acting as the responder on the CPU
//   data-memory port. One request at a time, WAIT_CYC wait states, then a
//   single-cycle completion strobe.
//
//   Parameters
//     ADDR_W    implemented address bits (depth 2**ADDR_W words)
//     WAIT_CYC  wait states before each access, 0..15
//   Ports
//     clk              system clock, rising edge
//     rst              asynchronous active-low reset
//     req_valid        request present
//     req_we           1 = store, 0 = load
//     req_addr         word address
//     req_wdata        store data
//     req_ready        request can be accepted this cycle
//     resp_valid       one-cycle completion strobe (loads and stores)
//     data_mem_to_cpu  registered load data, held between loads
//     resp_err         address out of range, qualified by resp_valid
module data_mem_responder #(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [15:0] data_mem_to_cpu,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        we_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        err_q;
   logic [15:0] rdata_q;
   logic        in_range;
   logic        access;

   logic [15:0] mem [2**ADDR_W];

   assign in_range = ((addr_q >> ADDR_W) == '0);
   assign access   = (state == BUSY) && (cnt == '0);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = BUSY;
         BUSY:    if (cnt == '0) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(WAIT_CYC);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) begin
            err_q <= !in_range;
            if (!we_q)
               rdata_q <= in_range ? mem[addr_q[ADDR_W-1:0]] : '0;
         end
      end
   end

   // Array has no reset; during reset the FSM sits in IDLE so no write fires.
   always_ff @(posedge clk) begin
      if (access && we_q && in_range)
         mem[addr_q[ADDR_W-1:0]] <= wdata_q;
   end

   // Gated by rst so the port reads not-ready while reset is held.
   assign req_ready       = rst && (state == IDLE);
   assign resp_valid      = (state == RESP);
   assign resp_err        = resp_valid && err_q;
   assign data_mem_to_cpu = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rv [4];
   logic        we [4];
   logic [15:0] ad [4];
   logic [15:0] wd [4];
   logic        rdy [4];
   logic        rsp [4];
   logic        er  [4];
   logic [15:0] dq  [4];

   // instance k has WAIT_CYC = {2,0,5,3}[k]
   data_mem_responder #(.ADDR_W(8), .WAIT_CYC(2)) u0 (.clk(clk), .rst(rst),
      .req_valid(rv[0]), .req_we(we[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
      .req_ready(rdy[0]), .resp_valid(rsp[0]), .data_mem_to_cpu(dq[0]), .resp_err(er[0]));
   data_mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) u1 (.clk(clk), .rst(rst),
      .req_valid(rv[1]), .req_we(we[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
      .req_ready(rdy[1]), .resp_valid(rsp[1]), .data_mem_to_cpu(dq[1]), .resp_err(er[1]));
   data_mem_responder #(.ADDR_W(8), .WAIT_CYC(5)) u2 (.clk(clk), .rst(rst),
      .req_valid(rv[2]), .req_we(we[2]), .req_addr(ad[2]), .req_wdata(wd[2]),
      .req_ready(rdy[2]), .resp_valid(rsp[2]), .data_mem_to_cpu(dq[2]), .resp_err(er[2]));
   data_mem_responder #(.ADDR_W(8), .WAIT_CYC(3)) u3 (.clk(clk), .rst(rst),
      .req_valid(rv[3]), .req_we(we[3]), .req_addr(ad[3]), .req_wdata(wd[3]),
      .req_ready(rdy[3]), .resp_valid(rsp[3]), .data_mem_to_cpu(dq[3]), .resp_err(er[3]));

   int tests = 0;
   int fails = 0;

   // reference model for instance 0: plain array of words plus last load value
   logic [15:0] mem_m [256];
   logic [15:0] last_m;

   typedef struct {
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_d;
      bit          exp_e;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model(input bit w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] exp_d, output bit exp_e);
      exp_e = (a > 16'h00FF);
      if (!w) last_m = exp_e ? 16'h0000 : mem_m[a[7:0]];
      else if (!exp_e) mem_m[a[7:0]] = d;
      exp_d = last_m;
   endtask

   // One transaction on instance k. lat = cycles from acceptance edge to the
   // resp_valid rise. bad flags ready/err/strobe-width protocol violations.
   task automatic xact(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output bit e, output int lat, output bit bad);
      int n;
      bad = 0; rd = '0; e = 0; lat = -1;
      @(negedge clk);
      rv[k] = 1'b1; we[k] = w; ad[k] = a; wd[k] = d;
      n = 0;
      while (!rdy[k] && n < 100) begin @(negedge clk); n++; end
      if (!rdy[k]) begin bad = 1; rv[k] = 1'b0; return; end
      @(posedge clk);
      @(negedge clk);
      rv[k] = 1'b0;
      lat = 0;
      while (!rsp[k] && lat < 100) begin
         if (rdy[k] || er[k]) bad = 1;
         @(negedge clk);
         lat++;
      end
      if (rdy[k] || !rsp[k]) bad = 1;
      rd = dq[k];
      e  = er[k];
      @(negedge clk);
      if (rsp[k] || er[k] || !rdy[k]) bad = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd, ed, ba [3], be [3], pd [3];
      bit e, ee, bad, seen;
      int lat, idx, np, pc [3];

      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin rv[k] = 1'b1; we[k] = 1'b1; ad[k] = 16'h0001; wd[k] = 16'hFFFF; end

      // reset held with req_valid high
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_ready", rdy[0], 0);
         chk("rst_resp", rsp[0], 0);
         chk("rst_data", dq[0], 0);
         chk("rst_err", er[0], 0);
      end
      for (int k = 0; k < 4; k++) rv[k] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", rdy[0], 1);
      chk("post_rst_ready_w0", rdy[1], 1);
      chk("post_rst_resp", rsp[0], 0);

      // known starting contents
      for (int i = 0; i < 256; i++) begin
         xact(0, 1'b1, 16'(i), 16'h0000, rd, e, lat, bad);
         mem_m[i] = 16'h0000;
      end
      last_m = 16'h0000;
      xact(3, 1'b1, 16'h0005, 16'h0000, rd, e, lat, bad);

      tbl[0]  = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
      tbl[2]  = '{1'b1, 16'h0112, 16'h1234, 16'hBEEF, 1'b1};
      tbl[3]  = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
      tbl[4]  = '{1'b0, 16'h0112, 16'h0000, 16'h0000, 1'b1};
      tbl[5]  = '{1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
      tbl[6]  = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
      tbl[7]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1};
      tbl[8]  = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
      tbl[9]  = '{1'b1, 16'h0100, 16'hFFFF, 16'h5A5A, 1'b1};
      tbl[10] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
      for (int i = 0; i < 11; i++) begin
         xact(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, e, lat, bad);
         chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_d);
         chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_e);
         chk($sformatf("tbl%0d_lat", i), lat, 3);
         chk($sformatf("tbl%0d_proto", i), bad, 0);
         model(tbl[i].w, tbl[i].a, tbl[i].d, ed, ee);
      end

      // wait-state sweep
      xact(1, 1'b0, 16'h0112, 16'h0000, rd, e, lat, bad);
      chk("w0_lat", lat, 1); chk("w0_err", e, 1); chk("w0_data", rd, 0); chk("w0_proto", bad, 0);
      xact(2, 1'b0, 16'h0112, 16'h0000, rd, e, lat, bad);
      chk("w5_lat", lat, 6); chk("w5_err", e, 1); chk("w5_data", rd, 0); chk("w5_proto", bad, 0);
      xact(1, 1'b1, 16'h0033, 16'hC0DE, rd, e, lat, bad);
      chk("w0_st_lat", lat, 1); chk("w0_st_data", rd, 0);
      xact(1, 1'b0, 16'h0033, 16'h0000, rd, e, lat, bad);
      chk("w0_ld_data", rd, 16'hC0DE); chk("w0_ld_err", e, 0); chk("w0_ld_proto", bad, 0);

      // back-to-back loads with req_valid held high
      ba[0] = 16'h0012; ba[1] = 16'h00FF; ba[2] = 16'h0112;
      for (int i = 0; i < 3; i++) model(1'b0, ba[i], 16'h0000, be[i], ee);
      idx = 0; np = 0;
      @(negedge clk);
      we[0] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (rsp[0]) begin
            if (np < 3) begin pc[np] = c; pd[np] = dq[0]; end
            np++;
         end
         if (rdy[0]) begin
            if (idx < 3) begin ad[0] = ba[idx]; rv[0] = 1'b1; idx++; end
            else rv[0] = 1'b0;
         end
         @(negedge clk);
      end
      rv[0] = 1'b0;
      chk("b2b_pulses", np, 3);
      if (np >= 3) begin
         chk("b2b_gap1", pc[1] - pc[0], 5);
         chk("b2b_gap2", pc[2] - pc[1], 5);
         for (int i = 0; i < 3; i++) chk($sformatf("b2b_data%0d", i), pd[i], be[i]);
      end

      // randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         bit w;
         logic [15:0] a, d;
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
         d = 16'($urandom);
         xact(0, w, a, d, rd, e, lat, bad);
         model(w, a, d, ed, ee);
         chk($sformatf("rnd%0d_data", i), rd, ed);
         chk($sformatf("rnd%0d_err", i), e, ee);
         chk($sformatf("rnd%0d_lat", i), lat, 3);
         chk($sformatf("rnd%0d_proto", i), bad, 0);
      end

      // reset one cycle after accepting a store (WAIT_CYC=3)
      @(negedge clk);
      rv[3] = 1'b1; we[3] = 1'b1; ad[3] = 16'h0005; wd[3] = 16'hAAAA;
      idx = 0;
      while (!rdy[3] && idx < 100) begin @(negedge clk); idx++; end
      chk("mid_rst_accept", rdy[3], 1);
      @(posedge clk);
      @(negedge clk);
      rv[3] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp[3]) seen = 1;
      end
      chk("mid_rst_ready", rdy[3], 0);
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rsp[3]) seen = 1;
      end
      chk("mid_rst_no_resp", seen, 0);
      xact(3, 1'b0, 16'h0005, 16'h0000, rd, e, lat, bad);
      chk("mid_rst_data", rd, 16'h0000);
      chk("mid_rst_err", e, 0);
      chk("mid_rst_lat", lat, 4);

      // instance 0 contents survive reset
      last_m = 16'h0000;
      model(1'b0, 16'h0012, 16'h0000, ed, ee);
      xact(0, 1'b0, 16'h0012, 16'h0000, rd, e, lat, bad);
      chk("keep_after_rst", rd, ed);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
